// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit-side stream arbiter.
package uart_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int BYTE_W = 8;

  // Index width for n items, never collapsing to zero bits.
  function automatic int clog2_min1(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer,
// wrapping past N_REQ-1 back to 0.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]             i_req,
  input  logic [clog2_min1(N_REQ)-1:0] i_ptr,
  output logic [N_REQ-1:0]             o_onehot,
  output logic [clog2_min1(N_REQ)-1:0] o_idx,
  output logic                         o_any
);

  localparam int PTR_W = clog2_min1(N_REQ);
  localparam int SUM_W = PTR_W + 1;

  logic [2*N_REQ-1:0] dbl_s;
  logic [N_REQ-1:0]   rot_s;
  logic [PTR_W-1:0]   off_s;
  logic [SUM_W-1:0]   sum_s;
  logic [PTR_W-1:0]   idx_s;

  // Rotate the doubled request vector so the pointer lands on bit 0, then
  // priority-encode the lowest set bit and map the offset back to an index.
  always_comb begin
    dbl_s = {i_req, i_req};
    for (int k = 0; k < N_REQ; k++) begin
      rot_s[k] = dbl_s[SUM_W'(k) + {1'b0, i_ptr}];
    end

    off_s = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        off_s = PTR_W'(k);
      end else begin
        off_s = off_s;
      end
    end

    sum_s = {1'b0, i_ptr} + {1'b0, off_s};
    if (sum_s >= SUM_W'(N_REQ)) begin
      idx_s = PTR_W'(sum_s - SUM_W'(N_REQ));
    end else begin
      idx_s = PTR_W'(sum_s);
    end

    o_any = |i_req;
    if (o_any) begin
      o_idx    = idx_s;
      o_onehot = N_REQ'(1) << idx_s;
    end else begin
      o_idx    = '0;
      o_onehot = '0;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one byte-wide AXIS sink
// (uart_tx) between N_REQ AXIS byte sources.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_REQ-1:0]          i_s_axis_tvalid,
  input  logic [N_REQ*BYTE_W-1:0]   i_s_axis_tdata,
  input  logic [N_REQ-1:0]          i_s_axis_tlast,
  output logic [N_REQ-1:0]          o_s_axis_tready,
  input  logic                      i_m_axis_tready,
  output logic                      o_m_axis_tvalid,
  output logic [BYTE_W-1:0]         o_m_axis_tdata,
  output logic                      o_m_axis_tlast,
  output logic [N_REQ-1:0]          o_grant,
  output logic                      o_busy
);

  localparam int PTR_W = clog2_min1(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] gidx_q, gidx_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [N_REQ-1:0]  pick_onehot_s;
  logic [PTR_W-1:0]  pick_idx_s;
  logic              pick_any_s;
  logic              sel_valid_s;
  logic              sel_last_s;
  logic [BYTE_W-1:0] sel_data_s;
  logic              accept_s;
  logic              release_s;
  logic [PTR_W-1:0]  ptr_next_s;

  uart_rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .i_req   (i_s_axis_tvalid),
    .i_ptr   (ptr_q),
    .o_onehot(pick_onehot_s),
    .o_idx   (pick_idx_s),
    .o_any   (pick_any_s)
  );

  // Owner pass-through mux; an all-zero grant yields all-zero outputs.
  always_comb begin
    sel_valid_s = |(i_s_axis_tvalid & grant_q);
    sel_last_s  = |(i_s_axis_tlast & grant_q);
    sel_data_s  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_q[k]) begin
        sel_data_s = sel_data_s | i_s_axis_tdata[k*BYTE_W +: BYTE_W];
      end else begin
        sel_data_s = sel_data_s;
      end
    end

    // Handshakes are suppressed while reset is asserted so no beat is lost
    // by a source that believes it was accepted.
    accept_s  = busy_q & sel_valid_s & i_m_axis_tready & ~i_rst;
    release_s = accept_s & (sel_last_s | (cnt_q == CNT_W'(MAX_BURST - 1)));

    if (gidx_q == PTR_W'(N_REQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = gidx_q + PTR_W'(1);
    end

    o_m_axis_tvalid = sel_valid_s & ~i_rst;
    o_m_axis_tdata  = sel_data_s;
    o_m_axis_tlast  = sel_last_s;
    o_s_axis_tready = grant_q & {N_REQ{i_m_axis_tready & ~i_rst}};
    o_grant         = grant_q;
    o_busy          = busy_q;
  end

  // Arbitration FSM next-state: grant on any request, release on the packet's
  // last beat or when the burst budget is spent.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;

    case (state_q)
      ARB_IDLE: begin
        if (pick_any_s) begin
          state_d = ARB_GRANT;
          grant_d = pick_onehot_s;
          gidx_d  = pick_idx_s;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = ARB_IDLE;
        end
      end

      ARB_GRANT: begin
        if (release_s) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          ptr_d   = ptr_next_s;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (accept_s) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end

      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        gidx_d  = '0;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench: default arbiter, a MAX_BURST=4 copy and an
// N_REQ=3 copy, all on one clock and reset.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [3:0]  a_svalid, a_slast, a_sready, a_grant;
  logic [31:0] a_sdata;
  logic        a_mready, a_mvalid, a_mlast, a_busy;
  logic [7:0]  a_mdata;

  logic [3:0]  b_svalid, b_slast, b_sready, b_grant;
  logic [31:0] b_sdata;
  logic        b_mready, b_mvalid, b_mlast, b_busy;
  logic [7:0]  b_mdata;

  logic [2:0]  c_svalid, c_slast, c_sready, c_grant;
  logic [23:0] c_sdata;
  logic        c_mready, c_mvalid, c_mlast, c_busy;
  logic [7:0]  c_mdata;

  uart_tx_arbiter #(.N_REQ(4), .MAX_BURST(16)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_s_axis_tvalid(a_svalid), .i_s_axis_tdata(a_sdata), .i_s_axis_tlast(a_slast),
    .o_s_axis_tready(a_sready), .i_m_axis_tready(a_mready),
    .o_m_axis_tvalid(a_mvalid), .o_m_axis_tdata(a_mdata), .o_m_axis_tlast(a_mlast),
    .o_grant(a_grant), .o_busy(a_busy)
  );

  uart_tx_arbiter #(.N_REQ(4), .MAX_BURST(4)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_s_axis_tvalid(b_svalid), .i_s_axis_tdata(b_sdata), .i_s_axis_tlast(b_slast),
    .o_s_axis_tready(b_sready), .i_m_axis_tready(b_mready),
    .o_m_axis_tvalid(b_mvalid), .o_m_axis_tdata(b_mdata), .o_m_axis_tlast(b_mlast),
    .o_grant(b_grant), .o_busy(b_busy)
  );

  uart_tx_arbiter #(.N_REQ(3), .MAX_BURST(16)) dut_c (
    .i_clk(clk), .i_rst(rst),
    .i_s_axis_tvalid(c_svalid), .i_s_axis_tdata(c_sdata), .i_s_axis_tlast(c_slast),
    .o_s_axis_tready(c_sready), .i_m_axis_tready(c_mready),
    .o_m_axis_tvalid(c_mvalid), .o_m_axis_tdata(c_mdata), .o_m_axis_tlast(c_mlast),
    .o_grant(c_grant), .o_busy(c_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    a_svalid = '0; a_slast = '0; a_sdata = '0; a_mready = 1'b0;
    b_svalid = '0; b_slast = '0; b_sdata = '0; b_mready = 1'b0;
    c_svalid = '0; c_slast = '0; c_sdata = '0; c_mready = 1'b0;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  logic [3:0] fair_exp [14] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0,
                                4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1};
  logic       bp_rdy   [7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [3:0] bp_sready[7]  = '{4'h0, 4'h8, 4'h0, 4'h0, 4'h8, 4'h8, 4'h0};
  logic [7:0] bp_data  [7]  = '{8'h00, 8'hA0, 8'hA1, 8'hA1, 8'hA1, 8'hA2, 8'h00};
  logic       bp_busy  [7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [3:0] bl_grant [9]  = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4, 4'h0, 4'h1};
  logic [7:0] bl_data  [9]  = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'hC0, 8'h00, 8'h14};
  logic       bl_last  [9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int beat [4];
    logic [3:0] acc;
    int bp_beat;
    int b0_beat;

    // Reset values.
    apply_reset();
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_grant", a_grant, 4'h0);
    check_eq("rst_busy", a_busy, 1'b0);
    check_eq("rst_mvalid", a_mvalid, 1'b0);
    check_eq("rst_sready", a_sready, 4'h0);
    check_eq("rst_mlast", a_mlast, 1'b0);
    check_eq("rst_mdata", a_mdata, 8'h00);
    nxt();
    rst = 1'b0;

    // Single requester 1: 0x41, 0x42, 0x43(last).
    a_mready = 1'b1;
    a_svalid = 4'b0010;
    a_sdata[15:8] = 8'h41;
    @(negedge clk);
    check_eq("single_idle_grant", a_grant, 4'h0);
    check_eq("single_idle_sready", a_sready, 4'h0);
    nxt();
    @(negedge clk);
    check_eq("single_grant", a_grant, 4'h2);
    check_eq("single_busy", a_busy, 1'b1);
    check_eq("single_b1_valid", a_mvalid, 1'b1);
    check_eq("single_b1_data", a_mdata, 8'h41);
    check_eq("single_sready", a_sready, 4'h2);
    nxt();
    a_sdata[15:8] = 8'h42;
    @(negedge clk);
    check_eq("single_b2_data", a_mdata, 8'h42);
    check_eq("single_b2_last", a_mlast, 1'b0);
    nxt();
    a_sdata[15:8] = 8'h43;
    a_slast[1] = 1'b1;
    @(negedge clk);
    check_eq("single_b3_data", a_mdata, 8'h43);
    check_eq("single_b3_last", a_mlast, 1'b1);
    nxt();
    a_svalid = '0;
    a_slast = '0;
    @(negedge clk);
    check_eq("single_release_busy", a_busy, 1'b0);
    check_eq("single_release_grant", a_grant, 4'h0);
    // Pointer should now be 2: with 1,2,3 requesting, 2 wins.
    a_svalid = 4'b1110;
    a_slast = 4'b1110;
    nxt();
    @(negedge clk);
    check_eq("single_ptr2_grant", a_grant, 4'h4);
    nxt();
    a_svalid = '0;
    @(negedge clk);
    check_eq("single_bubble", a_grant, 4'h0);

    // Fairness: four requesters with continuous 2-byte packets.
    apply_reset();
    a_mready = 1'b1;
    a_svalid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      beat[k] = 0;
      a_sdata[k*8 +: 8] = 8'(k*16);
      a_slast[k] = 1'b0;
    end
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      check_eq($sformatf("fair_c%0d", c), a_grant, fair_exp[c]);
      acc = a_svalid & a_sready;
      nxt();
      for (int k = 0; k < 4; k++) begin
        if (acc[k]) beat[k]++;
        a_sdata[k*8 +: 8] = 8'(k*16 + beat[k]);
        a_slast[k] = beat[k][0];
      end
    end

    // Backpressure on a 3-byte packet from requester 3.
    apply_reset();
    bp_beat = 0;
    a_svalid = 4'b1000;
    a_sdata[31:24] = 8'hA0;
    for (int c = 0; c < 7; c++) begin
      a_mready = bp_rdy[c];
      @(negedge clk);
      check_eq($sformatf("bp_sready_c%0d", c), a_sready, bp_sready[c]);
      check_eq($sformatf("bp_data_c%0d", c), a_mdata, bp_data[c]);
      check_eq($sformatf("bp_busy_c%0d", c), a_busy, bp_busy[c]);
      acc = a_svalid & a_sready;
      nxt();
      if (acc[3]) bp_beat++;
      if (bp_beat == 3) begin
        a_svalid = '0;
        a_slast = '0;
      end else begin
        a_sdata[31:24] = 8'(8'hA0 + bp_beat);
        a_slast[3] = (bp_beat == 2);
      end
    end

    // Reset after beat 2 of a 5-beat packet from requester 1.
    apply_reset();
    a_mready = 1'b1;
    a_svalid = 4'b0010;
    a_sdata[15:8] = 8'h60;
    nxt();
    a_sdata[15:8] = 8'h60;
    nxt();
    a_sdata[15:8] = 8'h61;
    nxt();
    a_sdata[15:8] = 8'h62;
    rst = 1'b1;
    a_svalid = 4'b0011;
    a_slast = 4'b0001;
    a_sdata[7:0] = 8'h77;
    @(negedge clk);
    check_eq("rstmid_sready_during", a_sready, 4'h0);
    check_eq("rstmid_mvalid_during", a_mvalid, 1'b0);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rstmid_grant", a_grant, 4'h0);
    check_eq("rstmid_mvalid", a_mvalid, 1'b0);
    check_eq("rstmid_busy", a_busy, 1'b0);
    nxt();
    @(negedge clk);
    check_eq("rstmid_req0_first", a_grant, 4'h1);
    check_eq("rstmid_req0_data", a_mdata, 8'h77);
    nxt();
    a_svalid = 4'b0010;
    a_slast = '0;
    @(negedge clk);
    check_eq("rstmid_bubble", a_grant, 4'h0);
    nxt();
    @(negedge clk);
    check_eq("rstmid_req1_next", a_grant, 4'h2);
    check_eq("rstmid_req1_data", a_mdata, 8'h62);

    // Burst limit 4: requester 0 streams without tlast, requester 2 waits.
    apply_reset();
    b0_beat = 0;
    b_mready = 1'b1;
    b_svalid = 4'b0101;
    b_slast = 4'b0100;
    b_sdata[7:0] = 8'h10;
    b_sdata[23:16] = 8'hC0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check_eq($sformatf("burst_grant_c%0d", c), b_grant, bl_grant[c]);
      check_eq($sformatf("burst_data_c%0d", c), b_mdata, bl_data[c]);
      check_eq($sformatf("burst_last_c%0d", c), b_mlast, bl_last[c]);
      acc = b_svalid & b_sready;
      nxt();
      if (acc[0]) begin
        b0_beat++;
        b_sdata[7:0] = 8'(8'h10 + b0_beat);
      end
      if (acc[2]) begin
        b_svalid[2] = 1'b0;
        b_slast[2] = 1'b0;
      end
    end

    // N_REQ=3 wrap: drive the pointer to 2, then requesters 0 and 1 contend.
    apply_reset();
    c_mready = 1'b1;
    c_svalid = 3'b010;
    c_slast = 3'b010;
    c_sdata[15:8] = 8'h31;
    @(negedge clk);
    check_eq("wrap_idle", c_grant, 3'b000);
    nxt();
    @(negedge clk);
    check_eq("wrap_first", c_grant, 3'b010);
    nxt();
    c_svalid = 3'b011;
    c_slast = 3'b011;
    c_sdata[7:0] = 8'h30;
    @(negedge clk);
    check_eq("wrap_bubble1", c_grant, 3'b000);
    nxt();
    @(negedge clk);
    check_eq("wrap_winner0", c_grant, 3'b001);
    check_eq("wrap_winner0_data", c_mdata, 8'h30);
    nxt();
    @(negedge clk);
    check_eq("wrap_bubble2", c_grant, 3'b000);
    nxt();
    @(negedge clk);
    check_eq("wrap_ptr1_winner", c_grant, 3'b010);
    check_eq("wrap_ptr1_data", c_mdata, 8'h31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
